// File: rtl/bypass_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : bypass_hazard_unit
// Description : Operand-bypass select and load-use stall generation for the
//               decode stage of a 7-stage pipeline. Tracks in-flight
//               destination registers in a 4-entry shadow pipeline
//               (execute, memory1, memory2, writeback).
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_hazard_unit #(
    parameter int CORE        = 0,
    parameter int REG_BITS    = 5,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   issue,
    input  logic                   flush,
    input  logic [6:0]             opcode,
    input  logic [REG_BITS-1:0]    rs1,
    input  logic [REG_BITS-1:0]    rs2,
    input  logic [REG_BITS-1:0]    rd,
    output logic                   stall,
    output logic [2:0]             rs1_data_bypass,
    output logic [2:0]             rs2_data_bypass,
    output logic [COUNT_WIDTH-1:0] stall_cycles,
    input  logic                   report
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // Shadow entry; index 0 = execute, 1 = memory1, 2 = memory2, 3 = writeback
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                is_load;
    } entry_t;

    entry_t [3:0]           r_shadow_q;
    entry_t [3:0]           w_shadow_d;
    logic [COUNT_WIDTH-1:0] r_stall_cycles_q;
    logic [COUNT_WIDTH-1:0] w_stall_cycles_d;

    logic   w_rs1_used;
    logic   w_rs2_used;
    logic   w_writes_rd;
    entry_t w_new_entry;
    logic   w_rs1_load_hit;
    logic   w_rs2_load_hit;

    // The per-cycle report dump is a simulation-only view; the port and core
    // index are retained so the interface matches the instrumented build.
    logic w_unused_report;
    assign w_unused_report = report & (CORE >= 0);

    // Returns {load_hazard, select}: nearest valid producer of src wins; a
    // load only hazards while it has not yet reached writeback.
    function automatic logic [3:0] f_lookup(
        input logic                i_used,
        input logic [REG_BITS-1:0] i_src,
        input entry_t [3:0]        i_sh
    );
        logic [2:0] v_sel;
        logic       v_ld;
        v_sel = 3'b000;
        v_ld  = 1'b0;
        if (i_used && (i_src != '0)) begin
            // Walk oldest to nearest so the nearest match overrides
            for (int k = 3; k >= 0; k--) begin
                if (i_sh[k].valid && (i_sh[k].rd == i_src)) begin
                    v_sel = 3'(k + 1);
                    v_ld  = i_sh[k].is_load && (k != 3);
                end
            end
        end
        return {v_ld, v_sel};
    endfunction

    // Decode source usage, destination write and build the candidate entry
    always_comb begin
        w_rs1_used  = !((opcode == c_OP_LUI) || (opcode == c_OP_AUIPC) ||
                        (opcode == c_OP_JAL));
        w_rs2_used  = (opcode == c_OP_RTYPE) || (opcode == c_OP_STORE) ||
                      (opcode == c_OP_BRANCH);
        w_writes_rd = !((opcode == c_OP_STORE) || (opcode == c_OP_BRANCH));
        w_new_entry.valid   = w_writes_rd && (rd != '0);
        w_new_entry.rd      = rd;
        w_new_entry.is_load = (opcode == c_OP_LOAD);
    end

    // Forwarding selects and load-use stall, purely combinational
    always_comb begin
        {w_rs1_load_hit, rs1_data_bypass} = f_lookup(w_rs1_used, rs1, r_shadow_q);
        {w_rs2_load_hit, rs2_data_bypass} = f_lookup(w_rs2_used, rs2, r_shadow_q);
        stall = issue && !flush && (w_rs1_load_hit || w_rs2_load_hit);
    end

    // Next shadow state: shift down, admit decode only when it really issues
    always_comb begin
        w_shadow_d[3] = r_shadow_q[2];
        w_shadow_d[2] = r_shadow_q[1];
        w_shadow_d[1] = r_shadow_q[0];
        w_shadow_d[0] = (issue && !stall && !flush) ? w_new_entry : '0;
    end

    // Saturating stall-cycle counter next value
    always_comb begin
        w_stall_cycles_d = r_stall_cycles_q;
        if (stall && (r_stall_cycles_q != '1)) begin
            w_stall_cycles_d = r_stall_cycles_q + COUNT_WIDTH'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow_q       <= '0;
            r_stall_cycles_q <= '0;
        end else begin
            r_shadow_q       <= w_shadow_d;
            r_stall_cycles_q <= w_stall_cycles_d;
        end
    end

    assign stall_cycles = r_stall_cycles_q;

endmodule
`default_nettype wire

// File: doc/bypass_hazard_unit.md
Name: bypass_hazard_unit

Overview:
- Sits directly upstream of the decode stage's operand muxes in the 7-stage pipeline: fetch1, fetch2, decode, execute, memory1, memory2, writeback.
- Drives the decode stage's 3-bit rs1/rs2 bypass selects and the pipeline-wide stall signal.
- Keeps a 4-entry shadow pipeline (execute, memory1, memory2, writeback) of in-flight destination registers.
- From that shadow pipeline it resolves operand forwarding and load-use hazards for the instruction currently in decode.

Parameters:
CORE, 0, core index; used only in report output
REG_BITS, 5, register select width
COUNT_WIDTH, 32, width of the stall-cycle counter

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
issue  input  1  decode holds a valid instruction
flush  input  1  instruction in decode is wrong-path; kill it
opcode  input  7  opcode of the decode instruction
rs1  input  REG_BITS  source register 1 of the decode instruction
rs2  input  REG_BITS  source register 2 of the decode instruction
rd  input  REG_BITS  destination register of the decode instruction
stall  output  1  hold fetch/decode; insert a bubble into execute
rs1_data_bypass  output  3  000 regfile, 001 execute, 010 memory1, 011 memory2, 100 writeback
rs2_data_bypass  output  3  same encoding as rs1_data_bypass
stall_cycles  output  COUNT_WIDTH  saturating count of cycles with stall=1
report  input  1  enables the per-cycle $display dump

Behaviour:
- Shadow entry format: {valid, rd, is_load}.
  - valid = 1 only when the instruction writes rd and rd != 0.
  - Opcodes that do not write rd: store 0100011, branch 1100011.
  - is_load = 1 when opcode == 0000011.
- Source-use decode:
  - rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used only by R-type 0110011, store and branch.
  - An unused source, or a source of x0, always selects 000 and never stalls.
- Forwarding select, combinational:
  - For each used source, search execute, memory1, memory2, writeback in that order.
  - The first valid entry whose rd equals the source wins; encode it as 001/010/011/100.
  - No match gives 000.
  - The nearest producer always wins, even if it is a load.
- Load-use stall, combinational:
  - stall = issue & ~flush & (either used source's winning match is a load in execute, memory1 or memory2).
  - A load in writeback forwards normally with select 100.
- Shadow update on each rising clock edge:
  - wb <= mem2, mem2 <= mem1, mem1 <= ex.
  - ex <= entry built from the decode instruction when issue & ~stall & ~flush; otherwise ex <= bubble (valid = 0).
- Flush has priority over stall: a flushed instruction never stalls and never enters ex.
- Regfile coherency: writeback writes the regfile at the same edge its entry leaves wb. On the following cycle the value is in the regfile and select 000 is correct.
- stall_cycles:
  - Increments by 1 at each rising edge where stall = 1.
  - Saturates at all-ones; never wraps.
- Reset (reset = 0, asynchronous):
  - All four shadow entries invalid.
  - stall_cycles = 0.
  - Outputs therefore settle to stall = 0 and both selects = 000.
  - Reset asserted mid-stall drops stall immediately, without waiting for a clock.
  - The first edge after deassertion shifts normally.
- Latency:
  - Selects and stall respond combinationally in the same cycle as decode inputs change.
  - Shadow state lags by one edge.

Test Plan:
- Reset then release with no issue -> stall = 0, both selects 000, stall_cycles = 0 for 10 cycles.
- add x5,x1,x2 issued, then add x6,x5,x5 next cycle -> rs1 and rs2 select 001, stall = 0. Same dependency one and two bubbles later -> 010, then 011. Same dependency three bubbles later -> 100. Four bubbles later -> 000.
- lw x5 issued, then add x6,x5,x0 held in decode -> stall = 1 for exactly 3 cycles, then rs1 select 100 with stall = 0, stall_cycles = 3. rs2 stays 000 (x0).
- addi x5 then lw x5 then add x7,x5,x5 -> nearest producer is the load, so stall = 3 cycles. The older addi is not forwarded.
- Load-use stall with flush = 1 in the first stall cycle -> stall drops that cycle, ex receives a bubble, no entry for the killed rd appears.
- reset pulsed low between clock edges during a stall -> stall = 0 immediately, shadow entries invalid, stall_cycles = 0. Writes to x0 never produce a nonzero select.
